// File: rtl/exe_unit_pipe.sv
// Signed execution unit: single-cycle ALU ops plus an iterative shift-add
// multiply, with valid/ready handshakes on both the issue and writeback sides.
module exe_unit_pipe #(
  parameter int ARG_BITS = 8,
  parameter int CNT_BITS = $clog2(ARG_BITS + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [2:0]          i_oper,
  input  logic [ARG_BITS-1:0] i_argA,
  input  logic [ARG_BITS-1:0] i_argB,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [ARG_BITS-1:0] o_result,
  output logic [3:0]          o_status
);

  localparam int N = ARG_BITS;
  localparam logic [N-1:0] MAX_C   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_C   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE_C   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] NB_C    = N'(N);
  localparam logic [N:0]   NW_C    = (N+1)'(N);
  localparam logic [CNT_BITS-1:0] LAST_C  = CNT_BITS'(N - 1);
  localparam logic [CNT_BITS-1:0] CINC_C  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [2*N-1:0]      acc_q;
  logic [2*N-1:0]      mcand_q;
  logic [N-1:0]        mplier_q;
  logic                neg_q;

  logic                accept_s;
  logic [N-1:0]        alu_res_s;
  logic                alu_ov_s;
  logic                alu_err_s;
  logic [N:0]          a_ext_s;
  logic [N:0]          b_ext_s;
  logic [N:0]          sum_s;
  logic [N:0]          diff_s;
  logic [N:0]          negb_s;
  logic [N-1:0]        abs_a_s;
  logic [N-1:0]        abs_b_s;
  logic [2*N-1:0]      acc_step_s;
  logic [2*N:0]        prod_s;
  logic [N-1:0]        mul_res_s;
  logic                mul_ov_s;

  function automatic logic parity_f(input logic [N-1:0] v);
    return ^v;
  endfunction

  function automatic logic [3:0] status_f(input logic [N-1:0] r, input logic ov,
                                          input logic err);
    return {err, &r, ov, parity_f(r)};
  endfunction

  // DONE forwards writeback readiness so a new op can issue as the old result retires.
  assign o_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
  assign accept_s = i_valid && o_ready;

  assign a_ext_s = {i_argA[N-1], i_argA};
  assign b_ext_s = {i_argB[N-1], i_argB};
  assign sum_s   = a_ext_s + b_ext_s;
  assign diff_s  = a_ext_s - b_ext_s;
  assign negb_s  = {(N+1){1'b0}} - b_ext_s;
  // Magnitudes are unsigned, so the most negative operand still has a representable |x|.
  assign abs_a_s = i_argA[N-1] ? ({N{1'b0}} - i_argA) : i_argA;
  assign abs_b_s = i_argB[N-1] ? ({N{1'b0}} - i_argB) : i_argB;

  // Single-cycle operation datapath.
  always_comb begin
    alu_res_s = {N{1'b0}};
    alu_ov_s  = 1'b0;
    alu_err_s = 1'b0;
    case (i_oper)
      3'd0: begin
        if (i_argB[N-1]) begin
          if (negb_s >= NW_C) begin
            alu_res_s = {N{1'b0}};
          end else begin
            alu_res_s = i_argA << negb_s;
          end
        end else begin
          alu_err_s = 1'b1;
        end
      end
      3'd1: begin
        alu_res_s = ($signed(i_argA) > $signed(i_argB)) ? ONE_C : {N{1'b0}};
      end
      3'd2: begin
        if (!i_argB[N-1] && (i_argB < NB_C)) begin
          alu_res_s = i_argA & ~(ONE_C << i_argB);
        end else begin
          alu_err_s = 1'b1;
        end
      end
      3'd3: begin
        alu_res_s = abs_a_s;
        alu_ov_s  = (i_argA == MIN_C);
      end
      3'd4: begin
        if (sum_s[N] != sum_s[N-1]) begin
          alu_ov_s  = 1'b1;
          alu_res_s = sum_s[N] ? MIN_C : MAX_C;
        end else begin
          alu_res_s = sum_s[N-1:0];
        end
      end
      3'd5: begin
        if (diff_s[N] != diff_s[N-1]) begin
          alu_ov_s  = 1'b1;
          alu_res_s = diff_s[N] ? MIN_C : MAX_C;
        end else begin
          alu_res_s = diff_s[N-1:0];
        end
      end
      default: begin
        alu_err_s = 1'b1;
      end
    endcase
  end

  // Final multiply step: the last partial product folds in combinationally before the sign is applied.
  always_comb begin
    acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {(2*N){1'b0}});
    if (neg_q) begin
      prod_s = {(2*N+1){1'b0}} - {1'b0, acc_step_s};
    end else begin
      prod_s = {1'b0, acc_step_s};
    end
    mul_res_s = prod_s[N-1:0];
    mul_ov_s  = !((&prod_s[2*N:N-1]) || !(|prod_s[2*N:N-1]));
  end

  // Control FSM with registered result, status and valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_BITS{1'b0}};
      acc_q    <= {(2*N){1'b0}};
      mcand_q  <= {(2*N){1'b0}};
      mplier_q <= {N{1'b0}};
      neg_q    <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= {N{1'b0}};
      o_status <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            if (i_oper == 3'd6) begin
              state_q  <= S_BUSY;
              cnt_q    <= {CNT_BITS{1'b0}};
              acc_q    <= {(2*N){1'b0}};
              mcand_q  <= {{N{1'b0}}, abs_a_s};
              mplier_q <= abs_b_s;
              neg_q    <= i_argA[N-1] ^ i_argB[N-1];
              o_valid  <= 1'b0;
            end else begin
              state_q  <= S_DONE;
              o_result <= alu_res_s;
              o_status <= status_f(alu_res_s, alu_ov_s, alu_err_s);
              o_valid  <= 1'b1;
            end
          end else if ((state_q == S_DONE) && i_ready) begin
            state_q <= S_IDLE;
            o_valid <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        S_BUSY: begin
          acc_q    <= acc_step_s;
          mcand_q  <= {mcand_q[2*N-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[N-1:1]};
          cnt_q    <= cnt_q + CINC_C;
          if (cnt_q == LAST_C) begin
            state_q  <= S_DONE;
            o_result <= mul_res_s;
            o_status <= status_f(mul_res_s, mul_ov_s, 1'b0);
            o_valid  <= 1'b1;
          end else begin
            state_q <= S_BUSY;
          end
        end
        default: begin
          state_q <= S_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_unit_pipe.sv
// Directed and randomized bench for exe_unit_pipe, checked against an
// integer-arithmetic reference model.
module tb_exe_unit_pipe;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic         o_ready;
  logic         o_valid;
  logic [2:0]   oper;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] o_result;
  logic [3:0]   o_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_unit_pipe #(.ARG_BITS(N)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_oper  (oper),
    .i_argA  (a),
    .i_argB  (b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_status(o_status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic, truncated to N bits at the end.
  function automatic void model(input int op, input int av, input int bv,
                                output logic [N-1:0] r, output logic [3:0] st);
    longint mx = (64'sd1 <<< (N - 1)) - 64'sd1;
    longint mn = -mx - 64'sd1;
    longint v  = 0;
    longint p;
    logic ov  = 1'b0;
    logic err = 1'b0;
    case (op)
      0: if (bv < 0) v = (-bv >= N) ? 0 : (longint'(av) <<< (-bv)); else err = 1'b1;
      1: v = (av > bv) ? 1 : 0;
      2: if (bv >= 0 && bv < N) v = longint'(av) & ~(64'sd1 <<< bv); else err = 1'b1;
      3: begin v = (av < 0) ? -longint'(av) : longint'(av); ov = (av == mn); end
      4, 5, 6: begin
        p = (op == 4) ? longint'(av) + bv : (op == 5) ? longint'(av) - bv : longint'(av) * bv;
        if (p > mx) begin v = (op == 6) ? p : mx; ov = 1'b1; end
        else if (p < mn) begin v = (op == 6) ? p : mn; ov = 1'b1; end
        else v = p;
      end
      default: err = 1'b1;
    endcase
    r  = v[N-1:0];
    st = {err, &r, ov, ^r};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [N-1:0] er, input logic [3:0] es, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; oper = op; a = av; b = bv;
    @(negedge clk);
    i_valid = 1'b0; oper = 3'($urandom); a = N'($urandom); b = N'($urandom);
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), (op == 3'd6) ? 32'(N + 1) : 32'd1);
    chk({tag, ".result"}, 32'(o_result), 32'(er));
    chk({tag, ".status"}, 32'(o_status), 32'(es));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk({tag, ".retire"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    logic [N-1:0] er;
    logic [3:0]   es;
    logic [N-1:0] av;
    logic [N-1:0] bv;
    logic [N-1:0] held_r;
    logic [3:0]   held_s;
    int           bi;
    int           op;
    logic         seen;

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; oper = 3'd0; a = '0; b = '0;
    #12;
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.result", 32'(o_result), 32'd0);
    chk("rst.status", 32'(o_status), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.ready", 32'(o_ready), 32'd1);

    run_op(3'd0, 8'h13, 8'hFE, 8'h4C, 4'b0001, "shl");
    run_op(3'd0, 8'h13, 8'h03, 8'h00, 4'b1000, "shl_err");
    run_op(3'd6, 8'd5, 8'hF9, 8'hDD, 4'b0000, "mul1");
    run_op(3'd6, 8'd12, 8'hF5, 8'h7C, 4'b0011, "mul2");
    run_op(3'd4, 8'd100, 8'd50, 8'h7F, 4'b0011, "sadd");
    run_op(3'd3, 8'h80, 8'h00, 8'h80, 4'b0011, "abs_min");
    run_op(3'd7, 8'h5A, 8'h21, 8'h00, 4'b1000, "rsvd");

    // Backpressure, then retire and issue on the same edge.
    @(negedge clk);
    i_valid = 1'b1; oper = 3'd1; a = 8'd5; b = 8'd3;
    @(negedge clk);
    i_valid = 1'b0;
    chk("bp.valid", 32'(o_valid), 32'd1);
    chk("bp.result", 32'(o_result), 32'd1);
    chk("bp.status", 32'(o_status), 32'b0001);
    held_r = o_result; held_s = o_status;
    a = 8'hC3; b = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold_result", 32'(o_result), 32'(held_r));
      chk("bp.hold_status", 32'(o_status), 32'(held_s));
      chk("bp.hold_ready", 32'(o_ready), 32'd0);
      chk("bp.hold_valid", 32'(o_valid), 32'd1);
    end
    i_ready = 1'b1; i_valid = 1'b1; oper = 3'd2; a = 8'hFF; b = 8'd7;
    #1;
    chk("b2b.ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b0;
    chk("b2b.valid", 32'(o_valid), 32'd1);
    chk("b2b.result", 32'(o_result), 32'h7F);
    chk("b2b.status", 32'(o_status), 32'b0001);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;

    // Reset in the third BUSY cycle of a multiply.
    i_valid = 1'b1; oper = 3'd6; a = 8'd5; b = 8'hF9;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstmul.valid", 32'(o_valid), 32'd0);
    chk("rstmul.result", 32'(o_result), 32'd0);
    chk("rstmul.status", 32'(o_status), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmul.ready", 32'(o_ready), 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | o_valid;
    end
    chk("rstmul.no_result", 32'(seen), 32'd0);

    for (int k = 0; k < 60; k++) begin
      op = int'($urandom_range(0, 7));
      av = N'($urandom);
      if ($urandom_range(0, 1) == 1) bi = int'($signed(N'($urandom)));
      else bi = int'($urandom_range(0, 18)) - 9;
      bv = bi[N-1:0];
      model(op, int'($signed(av)), int'($signed(bv)), er, es);
      run_op(op[2:0], av, bv, er, es, $sformatf("rnd%0d_op%0d", k, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
